sram_dump_ctrl: RTL and testbench

- Read-back companion to the serial SRAM loader: it is the reader for the loader's writer.
- Receives a serial command of start address and word count, then reads the SRAM port word by word.
- Shifts each word out serially, LSB first, with a valid strobe.
- Raises RDY when the dump is complete. Used to verify program/data memory contents after loading.

---
 rtl/sram_dump_ctrl.sv | 118 +++++++++++
 tb/tb_sram_dump_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sram_dump_ctrl.sv
// Serial-command SRAM reader: takes {count, start address} bit-serially,
// then streams each addressed word out LSB first with a valid strobe.
module sram_dump_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int CMD_BITS_WIDTH    = 2 * MEMORY_ADDR_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         LOAD_N,
  input  logic                         SI,
  input  logic [MEMORY_DATA_WIDTH-1:0] PI,
  output logic                         CEN,
  output logic                         D_WE,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic                         SO,
  output logic                         SO_VLD,
  output logic                         RDY
);

  localparam int DW = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int CB = CMD_BITS_WIDTH;
  localparam int CW = $clog2(CB > DW ? CB : DW);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    CAPT,
    SEND,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CB-1:0] cmd, cmd_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [AW-1:0] left, left_nx;
  logic [DW-1:0] shreg, shreg_nx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      cmd   <= '0;
      addr  <= '0;
      left  <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cmd   <= cmd_nx;
      addr  <= addr_nx;
      left  <= left_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cmd_nx   = cmd;
    addr_nx  = addr;
    left_nx  = left;
    shreg_nx = shreg;
    unique case (state)
      IDLE, DONE: begin
        if (!LOAD_N) begin
          state_nx = LOAD;
          cnt_nx   = CW'(CB - 1);
        end
      end
      LOAD: begin
        // first bit in ends up at bit 0
        cmd_nx = {SI, cmd[CB-1:1]};
        cnt_nx = cnt - CW'(1);
        if (cnt == '0) begin
          addr_nx  = cmd_nx[AW-1:0];
          left_nx  = cmd_nx[2*AW-1:AW];
          state_nx = RD;
        end
      end
      RD: begin
        state_nx = CAPT;
      end
      CAPT: begin
        shreg_nx = PI;
        cnt_nx   = CW'(DW - 1);
        state_nx = SEND;
      end
      SEND: begin
        shreg_nx = shreg >> 1;
        cnt_nx   = cnt - CW'(1);
        if (cnt == '0) begin
          if (left == '0) begin
            state_nx = DONE;
          end else begin
            addr_nx  = addr + AW'(1);
            left_nx  = left - AW'(1);
            state_nx = RD;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign CEN    = (state == RD);
  assign A      = (state == RD) ? addr : '0;
  assign SO     = (state == SEND) & shreg[0];
  assign SO_VLD = (state == SEND);
  assign RDY    = (state == DONE);
  assign D_WE   = 1'b0;

endmodule

// File: tb/tb_sram_dump_ctrl.sv
// Randomized bench for sram_dump_ctrl against a cycle-indexed
// golden model derived from command fields and a memory array.
module tb_sram_dump_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD_N;
  logic       SI;
  logic [7:0] PI = 8'h00;
  logic       CEN;
  logic       D_WE;
  logic [8:0] A;
  logic       SO;
  logic       SO_VLD;
  logic       RDY;

  logic [7:0] mem [512];
  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  sram_dump_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .LOAD_N (LOAD_N),
    .SI     (SI),
    .PI     (PI),
    .CEN    (CEN),
    .D_WE   (D_WE),
    .A      (A),
    .SO     (SO),
    .SO_VLD (SO_VLD),
    .RDY    (RDY)
  );

  // SRAM: data appears one cycle after an enabled cycle, junk otherwise
  always @(posedge CLK)
    PI <= CEN ? mem[A] : 8'($urandom);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // e = number of edges since the LOAD_N=0 edge; outputs sampled
  // on the negedge following edge e.
  task automatic run(input string tag,
                     input logic [8:0] sa,
                     input logic [8:0] cw,
                     input bit noise,
                     input int abort_e);
    logic [17:0] cmd;
    logic [8:0]  wa;
    logic [8:0]  e_a;
    logic        e_cen, e_vld, e_so, e_rdy;
    int n, last, p, w;
    int m_cen, m_a, m_vld, m_so, m_rdy, m_we;
    bit aborted;
    cmd = {cw, sa};
    n = int'(cw) + 1;
    last = 18 + 10 * n;
    m_cen = 0; m_a = 0; m_vld = 0;
    m_so = 0; m_rdy = 0; m_we = 0;
    aborted = 0;
    @(negedge CLK);
    LOAD_N = 1'b0;
    SI = 1'($urandom);
    @(posedge CLK);
    for (int e = 0; e <= last; e++) begin
      @(negedge CLK);
      e_cen = 0; e_a = '0; e_vld = 0; e_so = 0;
      e_rdy = (e == last);
      if (e >= 18 && e < last) begin
        p = (e - 18) % 10;
        w = (e - 18) / 10;
        wa = 9'(int'(sa) + w);
        if (p == 0) begin
          e_cen = 1;
          e_a = wa;
        end
        if (p >= 2) begin
          e_vld = 1;
          e_so = mem[wa][p-2];
        end
      end
      if (CEN !== e_cen) m_cen++;
      if (A !== e_a) m_a++;
      if (SO_VLD !== e_vld) m_vld++;
      if (SO !== e_so) m_so++;
      if (RDY !== e_rdy) m_rdy++;
      if (D_WE !== 1'b0) m_we++;
      if (e == abort_e) begin
        RST = 1'b1;
        LOAD_N = 1'b1;
        aborted = 1;
        break;
      end
      if (e < 18) SI = cmd[e];
      else SI = noise ? 1'($urandom) : 1'b0;
      LOAD_N = (noise && e < last) ? 1'($urandom) : 1'b1;
    end
    chk({tag, "_cen"}, m_cen, 0);
    chk({tag, "_a"}, m_a, 0);
    chk({tag, "_vld"}, m_vld, 0);
    chk({tag, "_so"}, m_so, 0);
    chk({tag, "_rdy"}, m_rdy, 0);
    chk({tag, "_we"}, m_we, 0);
    if (!aborted) chk({tag, "_done"}, RDY, 1);
  endtask

  initial begin
    RST = 1'b1;
    LOAD_N = 1'b1;
    SI = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[5] = 8'hA5;
    mem[6] = 8'h3C;
    mem[7] = 8'hFF;
    mem[9'h1FF] = 8'h81;
    repeat (3) @(negedge CLK);
    chk("rst_cen", CEN, 0);
    chk("rst_we", D_WE, 0);
    chk("rst_a", A, 0);
    chk("rst_so", SO, 0);
    chk("rst_vld", SO_VLD, 0);
    chk("rst_rdy", RDY, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_rdy", RDY, 0);

    run("basic", 9'h005, 9'd2, 0, -1);
    run("single", 9'h1FF, 9'd0, 0, -1);
    run("wrap", 9'h1FF, 9'd1, 0, -1);
    run("noise", 9'h005, 9'd2, 1, -1);

    // abort during 4th bit of the first word
    run("abort", 9'h005, 9'd2, 0, 23);
    @(negedge CLK);
    RST = 1'b0;
    chk("abt_cen", CEN, 0);
    chk("abt_a", A, 0);
    chk("abt_so", SO, 0);
    chk("abt_vld", SO_VLD, 0);
    chk("abt_rdy", RDY, 0);
    repeat (3) @(negedge CLK);
    chk("abt_idle", {CEN, SO_VLD, RDY}, 0);
    run("fresh", 9'h0A0, 9'd3, 0, -1);

    run("recmd", 9'h010, 9'd0, 0, -1);

    for (int r = 0; r < 6; r++)
      run("rand", 9'($urandom), 9'($urandom_range(0, 5)),
          1'($urandom), -1);

    run("full", 9'h000, 9'h1FF, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
